// File: rtl/clint_multi.sv
// Multi-hart core-local interruptor: msip, mtimecmp and mtime registers
// exposed on a split read/write bus with a prescaled 64-bit timer.
module clint_multi #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          HARTS     = 4,
  parameter logic [31:0] TICK_CNT  = 32'd1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RDEN,
  input  logic [31:0]      RIADDR,
  output logic [31:0]      ROADDR,
  output logic             RVALID,
  output logic [31:0]      RDATA,
  input  logic             WREN,
  input  logic [31:0]      WADDR,
  input  logic [31:0]      WDATA,
  input  logic             TIME_STOP,
  output logic [HARTS-1:0] MSIP,
  output logic [HARTS-1:0] MTIP
);

  localparam logic [31:0] WIN_SIZE = 32'h0001_0000;
  localparam logic [15:0] OFF_TLO  = 16'hBFF8;
  localparam logic [15:0] OFF_THI  = 16'hBFFC;

  logic [31:0]            presc_q, presc_d;
  logic [63:0]            mtime_q, mtime_d;
  logic [HARTS-1:0][63:0] cmp_q, cmp_d;
  logic [HARTS-1:0]       msip_q, msip_d;
  logic [HARTS-1:0]       mtip_q, mtip_d;
  logic                   rvalid_q, rvalid_d;
  logic [31:0]            roaddr_q, roaddr_d;
  logic [31:0]            rdata_q, rdata_d;

  logic [31:0] rd_rel, wr_rel;
  logic        rd_hit, wr_hit;
  logic [15:0] rd_off, wr_off;
  logic [31:0] rd_val;
  logic        tick;
  logic        we_tlo, we_thi;

  // Window membership is computed relative to the base so that a base
  // near the top of the address space cannot overflow the comparison.
  assign rd_rel = RIADDR - BASE_ADDR;
  assign wr_rel = WADDR - BASE_ADDR;
  assign rd_hit = RDEN && (rd_rel < WIN_SIZE);
  assign wr_hit = WREN && (wr_rel < WIN_SIZE);
  assign rd_off = RIADDR[15:0];
  assign wr_off = WADDR[15:0];

  assign MSIP   = msip_q;
  assign MTIP   = mtip_q;
  assign RVALID = rvalid_q;
  assign ROADDR = roaddr_q;
  assign RDATA  = rdata_q;

  // Read mux over current register values; unmapped offsets read as zero.
  always_comb begin
    rd_val = '0;
    for (int h = 0; h < HARTS; h++) begin
      if (rd_off == 16'(4 * h))
        rd_val = {31'b0, msip_q[h]};
      if (rd_off == 16'(32'h4000 + 8 * h))
        rd_val = cmp_q[h][31:0];
      if (rd_off == 16'(32'h4004 + 8 * h))
        rd_val = cmp_q[h][63:32];
    end
    if (rd_off == OFF_TLO)
      rd_val = mtime_q[31:0];
    if (rd_off == OFF_THI)
      rd_val = mtime_q[63:32];
  end

  // Next-state: prescaler, timer, writable registers, compare and read port.
  always_comb begin
    presc_d  = presc_q;
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    msip_d   = msip_q;
    mtip_d   = '0;
    tick     = 1'b0;
    we_tlo   = wr_hit && (wr_off == OFF_TLO);
    we_thi   = wr_hit && (wr_off == OFF_THI);
    rvalid_d = rd_hit;
    roaddr_d = rd_hit ? RIADDR : 32'h0;
    rdata_d  = rd_hit ? rd_val : 32'h0;

    if (!TIME_STOP) begin
      if (presc_q == TICK_CNT - 32'd1) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + 32'd1;
      end
    end

    for (int h = 0; h < HARTS; h++) begin
      mtip_d[h] = (mtime_q >= cmp_q[h]);
      if (wr_hit && wr_off == 16'(4 * h))
        msip_d[h] = WDATA[0];
      if (wr_hit && wr_off == 16'(32'h4000 + 8 * h))
        cmp_d[h][31:0] = WDATA;
      if (wr_hit && wr_off == 16'(32'h4004 + 8 * h))
        cmp_d[h][63:32] = WDATA;
    end

    // A software write to mtime wins over the tick in the same cycle.
    if (we_tlo)
      mtime_d[31:0] = WDATA;
    if (we_thi)
      mtime_d[63:32] = WDATA;
    if (tick && !we_tlo && !we_thi)
      mtime_d = mtime_q + 64'd1;
  end

  // State registers with synchronous reset; compares start disarmed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q  <= '0;
      mtime_q  <= '0;
      cmp_q    <= '1;
      msip_q   <= '0;
      mtip_q   <= '0;
      rvalid_q <= 1'b0;
      roaddr_q <= '0;
      rdata_q  <= '0;
    end else begin
      presc_q  <= presc_d;
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      msip_q   <= msip_d;
      mtip_q   <= mtip_d;
      rvalid_q <= rvalid_d;
      roaddr_q <= roaddr_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
